// File: rtl/gcd_datapath.sv
// Subtractive GCD datapath with IDLE/BUSY/DONE sequencing and result handshake.
// Optional iteration counter on iter_cnt: define GCD_ITER_CNT_EN to enable it.
module gcd_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x_sel,
  input  logic             y_sel,
  input  logic             x_en,
  input  logic             y_en,
  input  logic             out_en,
  output logic             x_lt_y,
  output logic             x_gt_y,
  output logic             x_eq_y,
  output logic [WIDTH-1:0] gcd_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] iter_cnt
);

  // state | meaning
  // IDLE  | waiting for operands under a load command
  // BUSY  | subtracting, one controller-commanded step per cycle
  // DONE  | gcd_out holds an undelivered result
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             load_cmd;
  logic             capture;
  logic             zero_op;
  logic             busy;
  logic             x_sub;
  logic             y_sub;
  logic             finish;

  assign load_cmd = x_en & y_en & ~x_sel & ~y_sel;
  assign in_ready = (state == IDLE) & load_cmd;
  assign capture  = in_valid & in_ready;
  assign zero_op  = (a_in == '0) | (b_in == '0);
  assign busy     = (state == BUSY);

  assign x_lt_y = busy & (x < y);
  assign x_gt_y = busy & (x > y);
  assign x_eq_y = busy & (x == y);

  // A subtraction only applies when it cannot underflow.
  assign x_sub  = busy & x_sel & x_en & (x > y);
  assign y_sub  = busy & y_sel & y_en & (y > x);
  assign finish = busy & out_en & (x == y);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      gcd_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            x <= a_in;
            y <= b_in;
            if (zero_op) begin
              gcd_out   <= a_in | b_in;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (x_sub) x <= x - y;
          if (y_sub) y <= y - x;
          if (finish) begin
            gcd_out   <= x;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of applied subtractions, cleared on each new capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (capture) begin
      cnt_q <= '0;
    end else if ((x_sub || y_sub) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign iter_cnt = cnt_q;
`else
  assign iter_cnt = '0;
`endif

endmodule

// File: doc/gcd_datapath.md
GCD_DATAPATH -- requirements
Module: gcd_datapath

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter CNT_W, default 8, iteration-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 a_in, b_in  input  WIDTH each  operands for new computation.
REQ-006 in_valid  input  1  operands on a_in/b_in valid.
REQ-007 in_ready  output  1  datapath accepts operands this cycle.
REQ-008 x_sel, y_sel, x_en, y_en, out_en  input  1 each  commands from the GCD controller.
REQ-009 x_lt_y, x_gt_y, x_eq_y  output  1 each  comparison flags to the controller.
REQ-010 gcd_out  output  WIDTH  result register.
REQ-011 out_valid  output  1  gcd_out holds an undelivered result.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 iter_cnt  output  CNT_W  subtraction steps for the current/last result.

Function
REQ-014 Internal registers x, y (WIDTH); state machine IDLE, BUSY, DONE.
REQ-015 in_ready = 1 only when state=IDLE and controller issues load (x_en=1, y_en=1, x_sel=0, y_sel=0).
REQ-016 Capture on in_valid && in_ready: x<=a_in, y<=b_in, iter_cnt<=0; next state BUSY, or DONE if either operand is 0.
REQ-017 Zero operand at capture: gcd_out<=a_in|b_in (gcd(a,0)=a, gcd(0,0)=0), out_valid=1 next cycle; BUSY skipped.
REQ-018 In BUSY: x_sel=1 && x_en=1 && x>y -> x<=x-y; y_sel=1 && y_en=1 && y>x -> y<=y-x; one step per cycle.
REQ-019 Command inconsistent with comparison (would underflow) ignored; register holds; no wrap-around ever occurs.
REQ-020 Both subtract commands in same cycle: only the one satisfying REQ-018 applies.
REQ-021 iter_cnt increments once per applied subtraction; saturates at 2^CNT_W-1.
REQ-022 Flags = unsigned compare of registered x, y, exactly one high, in BUSY only; all 0 in IDLE and DONE.
REQ-023 In BUSY, out_en=1 && x_eq_y=1 -> gcd_out<=x, out_valid=1, state DONE next edge; out_en with x!=y ignored.
REQ-024 DONE: gcd_out, iter_cnt, out_valid held stable until out_valid && out_ready; next edge out_valid=0, state IDLE.
REQ-025 Operand loads (x_sel=0/y_sel=0 with enable) outside IDLE ignored; in_valid outside IDLE ignored.
REQ-026 out_ready with out_valid=0 has no effect.

Reset
REQ-027 rst=0 at a rising edge, in any state including mid-BUSY: state IDLE, x=0, y=0, gcd_out=0, out_valid=0, iter_cnt=0; in-flight computation discarded.
REQ-028 After reset, flags 000; in_ready follows REQ-015 from first cycle with rst=1.

Configuration
REQ-029 Macro GCD_ITER_CNT_EN defined: counter per REQ-021 implemented and driven on iter_cnt.
REQ-030 GCD_ITER_CNT_EN undefined: no counter logic; iter_cnt tied to 0; all other behaviour identical.

Verification
REQ-031 a=48, b=18, controller-modelled commands -> gcd_out=6, out_valid=1, iter_cnt=4 (macro on), 0 (macro off).
REQ-032 a=7, b=7 -> x_eq_y=1 first BUSY cycle; out_en -> gcd_out=7 next edge, iter_cnt=0.
REQ-033 a=0, b=9 -> state DONE one cycle after capture, gcd_out=9, flags 000; a=0, b=0 -> gcd_out=0.
REQ-034 Result ready, out_ready=0 for 5 cycles -> gcd_out, out_valid stable; out_ready=1 -> out_valid=0 next edge, in_ready=1 when load commanded.
REQ-035 rst=0 during BUSY of a=200, b=3 -> next edge all outputs 0, state IDLE; new a=12, b=8 -> gcd_out=4.
REQ-036 In BUSY with x=5, y=9, force x_sel=1, x_en=1 -> x stays 5, no underflow, iter_cnt unchanged.
